// File: rtl/cover_toggle_collector_if.sv
// rtl/cover_toggle_collector_if.sv - hit input, control and bitmap readout signals of the coverage collector
interface cover_toggle_collector_if #(
  parameter int COVER_TOTAL = 8065,
  parameter int W           = 8,
  parameter int WORD        = 32,
  parameter int IDX_W       = $clog2(COVER_TOTAL),
  parameter int NWORDS      = (COVER_TOTAL + WORD - 1) / WORD,
  parameter int AW          = (NWORDS > 1) ? $clog2(NWORDS) : 1
);
  logic             in_valid;
  logic [IDX_W-1:0] in_index;
  logic [W-1:0]     in_bits;
  logic             clear;
  logic             dump_start;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_addr;
  logic [WORD-1:0]  out_data;
  logic             dump_done;
  logic             busy;
  logic [IDX_W:0]   covered_count;

  // Producer of hits/commands and consumer of readout words
  modport master (
    output in_valid, in_index, in_bits, clear, dump_start, out_ready,
    input  out_valid, out_addr, out_data, dump_done, busy, covered_count
  );

  // The collector itself
  modport slave (
    input  in_valid, in_index, in_bits, clear, dump_start, out_ready,
    output out_valid, out_addr, out_data, dump_done, busy, covered_count
  );
endinterface

// File: rtl/cover_toggle_collector.sv
// rtl/cover_toggle_collector.sv - toggle-coverage bitmap sink with distinct-hit counter and word readout
module cover_toggle_collector #(
  parameter int COVER_TOTAL = 8065,
  parameter int W           = 8,
  parameter int WORD        = 32,
  parameter int IDX_W       = $clog2(COVER_TOTAL)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cover_toggle_collector_if.slave bus
);
  localparam int NWORDS = (COVER_TOTAL + WORD - 1) / WORD;
  localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW     = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q;
  // Padded to whole words; padding bits are never set, so the tail of the last word reads 0
  logic [NWORDS*WORD-1:0] bitmap_q;
  logic [IDX_W:0]         count_q, count_d;
  logic [W-1:0]           hit_en;
  logic [IDX_W:0]         hit_pt [W];
  logic [CW-1:0]          hit_cnt;
  logic                   do_clear;
  logic [AW-1:0]          addr_q, load_addr;
  logic [WORD-1:0]        data_q, load_word;
  logic                   valid_q, done_q, busy_q;

  assign do_clear = (state_q == IDLE) && bus.clear;

  // Per-lane hit decode: in range and not already covered -> new point
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < W; i++) begin
      hit_pt[i] = {1'b0, bus.in_index} + (IDX_W+1)'(i);
      hit_en[i] = bus.in_valid && bus.in_bits[i]
                  && (hit_pt[i] < (IDX_W+1)'(COVER_TOTAL))
                  && !bitmap_q[hit_pt[i][IDX_W-1:0]];
      hit_cnt   = hit_cnt + CW'(hit_en[i]);
    end
    count_d = count_q + (IDX_W+1)'(hit_cnt);
  end

  // Word to capture: word 0 when starting a dump, else the one after the current
  always_comb begin
    load_addr = (state_q == IDLE) ? '0 : addr_q + AW'(1);
    load_word = bitmap_q[int'(load_addr)*WORD +: WORD];
  end

  // Bitmap and distinct-point counter; clear in IDLE overrides any same-cycle hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitmap_q <= '0;
      count_q  <= '0;
    end else if (do_clear) begin
      bitmap_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < W; i++) begin
        if (hit_en[i]) bitmap_q[hit_pt[i][IDX_W-1:0]] <= 1'b1;
      end
    end
  end

  // Readout FSM with registered stream outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (!bus.clear && bus.dump_start) begin
            state_q <= SEND;
            addr_q  <= load_addr;
            data_q  <= load_word;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (addr_q == AW'(NWORDS - 1)) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= load_addr;
              data_q <= load_word;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_addr      = addr_q;
  assign bus.out_data      = data_q;
  assign bus.dump_done     = done_q;
  assign bus.busy          = busy_q;
  assign bus.covered_count = count_q;
endmodule
